// File: rtl/beat_rate_ctrl.sv
// Heart-rate measurement front end: input conditioning, gated beat count, bpm conversion and alarm.
// Optional BPM_AVG_EN: each capture is averaged with the previous one.
module beat_rate_ctrl #(
  parameter int TICK_DIV = 1_000_000,
  parameter int WINDOW_S = 15,
  parameter int SCALE    = 4,
  parameter int DEB_CYC  = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cls,
  input  logic       pulse_in,
  input  logic [7:0] set_pulso,
  output logic [7:0] bpm,
  output logic       bpm_valid,
  output logic       alarm,
  output logic       en_count,
  output logic       en_cap,
  output logic       clear,
  output logic       busy
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (WINDOW_S > 1) ? $clog2(WINDOW_S) : 1;
  localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CLEAR   = 2'd1,
    S_COUNT   = 2'd2,
    S_CAPTURE = 2'd3
  } state_e;

  logic [1:0]    start_sync_q, cls_sync_q, pulse_sync_q;
  logic          start_prev_q;
  logic          lvl_q, lvl_d, lvl_prev_q;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  state_e        state_q, state_d;
  logic [7:0]    beat_cnt_q, beat_cnt_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [SW-1:0] sec_q, sec_d;
  logic [7:0]    bpm_q, bpm_d;
  logic          bpm_valid_q, bpm_valid_d;
  logic          alarm_q, alarm_d;
  logic          en_count_q, en_cap_q, clear_q, busy_q;

  logic          start_s, cls_s, pulse_s, start_rise_s, beat_s;
  logic [31:0]   prod_s;
  logic [7:0]    raw_s, cap_s;

  assign start_s      = start_sync_q[1];
  assign cls_s        = cls_sync_q[1];
  assign pulse_s      = pulse_sync_q[1];
  assign start_rise_s = start_s & ~start_prev_q;
  assign beat_s       = lvl_q & ~lvl_prev_q;

  // Input synchronizers and edge-detect history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_sync_q <= 2'b00;
      cls_sync_q   <= 2'b00;
      pulse_sync_q <= 2'b00;
      start_prev_q <= 1'b0;
      lvl_prev_q   <= 1'b0;
    end else begin
      start_sync_q <= {start_sync_q[0], start};
      cls_sync_q   <= {cls_sync_q[0], cls};
      pulse_sync_q <= {pulse_sync_q[0], pulse_in};
      start_prev_q <= start_s;
      lvl_prev_q   <= lvl_q;
    end
  end

  // Debounce: the level follows the input only after DEB_CYC consecutive differing cycles.
  always_comb begin
    lvl_d     = lvl_q;
    deb_cnt_d = '0;
    if (pulse_s != lvl_q) begin
      if (deb_cnt_q == DW'(DEB_CYC - 1)) begin
        lvl_d     = pulse_s;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
    end else begin
      deb_cnt_d = '0;
    end
  end

  // Full-width product so large counts saturate instead of wrapping.
  assign prod_s = 32'(beat_cnt_q) * 32'(SCALE);
  assign raw_s  = (prod_s > 32'd255) ? 8'hFF : prod_s[7:0];

`ifdef BPM_AVG_EN
  // bpm_valid marks whether a previous capture exists to average with.
  assign cap_s = bpm_valid_q ? 8'(({1'b0, bpm_q} + {1'b0, raw_s} + 9'd1) >> 1) : raw_s;
`else
  assign cap_s = raw_s;
`endif

  // Next-state, counters and result logic.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    tick_d      = tick_q;
    sec_d       = sec_q;
    bpm_d       = bpm_q;
    bpm_valid_d = bpm_valid_q;
    alarm_d     = alarm_q;
    case (state_q)
      S_IDLE: begin
        if (start_rise_s) begin
          state_d = S_CLEAR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        beat_cnt_d = 8'd0;
        tick_d     = '0;
        sec_d      = '0;
        state_d    = S_COUNT;
      end
      S_COUNT: begin
        if (beat_s && (beat_cnt_q != 8'hFF)) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
        if (tick_q == TW'(TICK_DIV - 1)) begin
          tick_d = '0;
          if (sec_q == SW'(WINDOW_S - 1)) begin
            sec_d   = '0;
            state_d = S_CAPTURE;
          end else begin
            sec_d = sec_q + SW'(1);
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      S_CAPTURE: begin
        bpm_d       = cap_s;
        bpm_valid_d = 1'b1;
        alarm_d     = (cap_s > set_pulso);
        state_d     = S_CLEAR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Abort wins over everything, including a capture in progress.
    if (cls_s) begin
      state_d     = S_IDLE;
      bpm_d       = 8'd0;
      bpm_valid_d = 1'b0;
      alarm_d     = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  // State, counters, results and status flags (flags decoded from next state so they align with state_q).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q       <= 1'b0;
      deb_cnt_q   <= '0;
      state_q     <= S_IDLE;
      beat_cnt_q  <= 8'd0;
      tick_q      <= '0;
      sec_q       <= '0;
      bpm_q       <= 8'd0;
      bpm_valid_q <= 1'b0;
      alarm_q     <= 1'b0;
      en_count_q  <= 1'b0;
      en_cap_q    <= 1'b0;
      clear_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      lvl_q       <= lvl_d;
      deb_cnt_q   <= deb_cnt_d;
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      tick_q      <= tick_d;
      sec_q       <= sec_d;
      bpm_q       <= bpm_d;
      bpm_valid_q <= bpm_valid_d;
      alarm_q     <= alarm_d;
      en_count_q  <= (state_d == S_COUNT);
      en_cap_q    <= (state_d == S_CAPTURE);
      clear_q     <= (state_d == S_CLEAR);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign bpm       = bpm_q;
  assign bpm_valid = bpm_valid_q;
  assign alarm     = alarm_q;
  assign en_count  = en_count_q;
  assign en_cap    = en_cap_q;
  assign clear     = clear_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_beat_rate_ctrl.sv
// Scoreboard bench for beat_rate_ctrl: random pulse trains per window, expected bpm/alarm queued per capture.
module tb_beat_rate_ctrl;

  localparam int TICK_DIV  = 250;
  localparam int WINDOW_S  = 3;
  localparam int SCALE     = 4;
  localparam int DEB_CYC   = 4;
  localparam int COUNT_LEN = TICK_DIV * WINDOW_S;
  localparam int PERIOD    = COUNT_LEN + 2;
  localparam int BUDGET    = COUNT_LEN - 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       cls = 1'b0;
  logic       pulse_in = 1'b0;
  logic [7:0] set_pulso = 8'd0;
  logic [7:0] bpm;
  logic       bpm_valid, alarm, en_count, en_cap, clear, busy;

  beat_rate_ctrl #(
    .TICK_DIV(TICK_DIV), .WINDOW_S(WINDOW_S), .SCALE(SCALE), .DEB_CYC(DEB_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cls(cls), .pulse_in(pulse_in),
    .set_pulso(set_pulso), .bpm(bpm), .bpm_valid(bpm_valid), .alarm(alarm),
    .en_count(en_count), .en_cap(en_cap), .clear(clear), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int bpm;
    int alarm;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   t = 0;
  int   prev_bpm = 0;
  bit   have_prev = 1'b0;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    t++;
  endtask

  task automatic wait_to(int tt);
    while (t < tt) step();
  endtask

  task automatic pulse(int h, int l);
    pulse_in = 1'b1;
    repeat (h) step();
    pulse_in = 1'b0;
    repeat (l) step();
  endtask

  // Drive one window's pulses well inside COUNT and queue what the capture must show.
  // n_good < 0 selects a fully random train; sp < 0 selects a random threshold.
  task automatic run_window(int n, int n_good, int n_glitch, int sp);
    int used, beats, h, l, target, raw, v;
    used = 0;
    beats = 0;
    wait_to(14 + PERIOD * n);
    set_pulso = (sp < 0) ? 8'($urandom_range(0, 255)) : 8'(sp);
    if (n_good < 0) begin
      target = $urandom_range(0, 75);
      for (int i = 0; i < target; i++) begin
        h = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DEB_CYC - 1) : $urandom_range(DEB_CYC, 8);
        l = $urandom_range(6, 9);
        if (used + h + l > BUDGET) break;
        pulse(h, l);
        used += h + l;
        if (h >= DEB_CYC) beats++;
      end
    end else begin
      for (int i = 0; i < n_good + n_glitch; i++) begin
        h = (i < n_good) ? 5 : 3;
        if (used + h + 6 > BUDGET) break;
        pulse(h, 6);
        used += h + 6;
        if (h >= DEB_CYC) beats++;
      end
    end
    raw = beats * SCALE;
    if (raw > 255) raw = 255;
`ifdef BPM_AVG_EN
    v = have_prev ? (prev_bpm + raw + 1) / 2 : raw;
`else
    v = raw;
`endif
    prev_bpm  = v;
    have_prev = 1'b1;
    sb_q.push_back('{bpm: v, alarm: (v > int'(set_pulso)) ? 1 : 0});
  endtask

  // Monitor: check window length at en_cap, then results and the follow-on clear one cycle later.
  int run_len = 0;
  bit pend = 1'b0;
  exp_t e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (pend) begin
        pend = 1'b0;
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_capture: got bpm %0d expected no capture at %0t", bpm, $time);
        end else begin
          e = sb_q.pop_front();
          chk("bpm", int'(bpm), e.bpm);
          chk("alarm", int'(alarm), e.alarm);
          chk("bpm_valid", int'(bpm_valid), 1);
          chk("clear_after_cap", int'(clear), 1);
        end
      end
      if (clear) run_len = 0;
      if (en_count) run_len++;
      if (en_cap) begin
        chk("count_len", run_len, COUNT_LEN);
        pend = 1'b1;
      end
    end
  end

  task automatic chk_all_zero(string tag);
    chk({tag, "_bpm"}, int'(bpm), 0);
    chk({tag, "_valid"}, int'(bpm_valid), 0);
    chk({tag, "_alarm"}, int'(alarm), 0);
    chk({tag, "_flags"}, int'({en_count, en_cap, clear, busy}), 0);
  endtask

  initial begin
    #(3_000_000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #20;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_reset", int'(busy), 0);

    // Continuous measurement from one start edge.
    start = 1'b1;
    t = 0;
    wait_to(5);
    start = 1'b0;
    run_window(0, 5, 0, 19);
    run_window(1, 5, 0, 20);
    run_window(2, 0, 10, -1);
    run_window(3, 12, 0, -1);
    run_window(4, 65, 0, 200);
    for (int w = 5; w < 9; w++) run_window(w, -1, 0, -1);

    // Abort part-way through the next COUNT.
    wait_to(14 + PERIOD * 9 + 200);
    cls = 1'b1;
    step();
    step();
    chk("abort_still_busy", int'(busy), 1);
    step();
    chk_all_zero("abort");
    have_prev = 1'b0;
    start = 1'b1;
    repeat (6) step();
    chk("start_with_cls", int'(busy), 0);
    cls = 1'b0;
    repeat (5) step();
    chk("start_held_no_edge", int'(busy), 0);
    start = 1'b0;
    repeat (3) step();

    // Fresh start after abort: first capture is not averaged with anything.
    start = 1'b1;
    t = 0;
    step();
    step();
    chk("start_latency_idle", int'(busy), 0);
    step();
    chk("start_latency_clear", int'({busy, clear}), 3);
    start = 1'b0;
    run_window(0, 5, 0, 19);
    run_window(1, 12, 0, 40);
    wait_to(PERIOD * 2 + 4);

    // Reset between clock edges must clear outputs at once.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    #20 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_async_reset", int'(busy), 0);
    chk("sb_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
